mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 292 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between an instruction-fetch
// requester and a load/store requester. Ties are broken round-robin. Load data
// is lane-extracted and extended, and store data is replicated across lanes.
// Define MEM_TIMEOUT_EN to abort memory accesses that stall for 255 cycles.
module mem_port_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    output logic        if_err,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [1:0]  ls_digit,
    input  logic        ls_sign,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_ack,
    output logic [31:0] ls_rdata,
    output logic        ls_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        stall
);

    typedef enum logic [1:0] {IDLE, IF_ACC, LS_ACC, RESP} state_t;

    localparam logic GRANT_IF = 1'b0;
    localparam logic GRANT_LS = 1'b1;

    state_t      state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic [1:0]  lat_lane_q, lat_lane_d;
    logic [1:0]  lat_digit_q, lat_digit_d;
    logic        lat_sign_q, lat_sign_d;
    logic        lat_we_q, lat_we_d;
    logic        lat_err_q, lat_err_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        if_ack_q, if_ack_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic        if_err_q, if_err_d;
    logic        ls_ack_q, ls_ack_d;
    logic [31:0] ls_rdata_q, ls_rdata_d;
    logic        ls_err_q, ls_err_d;
`ifdef MEM_TIMEOUT_EN
    logic [7:0]  tmo_q, tmo_d;
`endif

    logic [3:0]  ls_be_new;
    logic [31:0] ls_wdata_new;
    logic        ls_misaligned;
    logic        finish;
    logic        finish_err;
    logic [31:0] finish_data;

    // Fetches are always whole aligned words, so the low fetch address bits carry no information.
    logic unused_if_lanes;
    assign unused_if_lanes = ^if_addr[1:0];

    // Pick the requested lane out of the memory word and extend it to 32 bits.
    function automatic logic [31:0] extract_load(input logic [31:0] word, input logic [1:0] lane,
                                                 input logic [1:0] digit, input logic sign);
        logic [7:0]  b;
        logic [15:0] h;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (digit)
            2'b00:   extract_load = {{24{sign & b[7]}}, b};
            2'b01:   extract_load = {{16{sign & h[15]}}, h};
            default: extract_load = word;
        endcase
    endfunction

    // Byte enables, store lane replication and the alignment check for an incoming load/store.
    always_comb begin
        ls_be_new     = 4'b1111;
        ls_wdata_new  = ls_wdata;
        ls_misaligned = 1'b0;
        case (ls_digit)
            2'b00: begin
                ls_be_new    = 4'b0001 << ls_addr[1:0];
                ls_wdata_new = {4{ls_wdata[7:0]}};
            end
            2'b01: begin
                ls_be_new     = 4'b0011 << {ls_addr[1], 1'b0};
                ls_wdata_new  = {2{ls_wdata[15:0]}};
                ls_misaligned = ls_addr[0];
            end
            default: begin
                ls_misaligned = (ls_addr[1:0] != 2'b00);
            end
        endcase
    end

    // Arbitration FSM: grant in IDLE, drive the memory port in *_ACC, acknowledge in RESP.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        lat_lane_d   = lat_lane_q;
        lat_digit_d  = lat_digit_q;
        lat_sign_d   = lat_sign_q;
        lat_we_d     = lat_we_q;
        lat_err_d    = lat_err_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_be_d     = mem_be_q;
        mem_wdata_d  = mem_wdata_q;
        if_ack_d     = if_ack_q;
        if_rdata_d   = if_rdata_q;
        if_err_d     = if_err_q;
        ls_ack_d     = ls_ack_q;
        ls_rdata_d   = ls_rdata_q;
        ls_err_d     = ls_err_q;
`ifdef MEM_TIMEOUT_EN
        tmo_d        = tmo_q;
`endif
        finish       = 1'b0;
        finish_err   = 1'b0;
        finish_data  = '0;

        case (state_q)
            IDLE: begin
                if (if_req && (!ls_req || last_grant_q == GRANT_LS)) begin
                    state_d      = IF_ACC;
                    last_grant_d = GRANT_IF;
                    lat_lane_d   = 2'b00;
                    lat_digit_d  = 2'b10;
                    lat_sign_d   = 1'b0;
                    lat_we_d     = 1'b0;
                    lat_err_d    = 1'b0;
                    mem_req_d    = 1'b1;
                    mem_we_d     = 1'b0;
                    mem_addr_d   = {if_addr[31:2], 2'b00};
                    mem_be_d     = 4'b1111;
                    mem_wdata_d  = '0;
`ifdef MEM_TIMEOUT_EN
                    tmo_d        = '0;
`endif
                end else if (ls_req) begin
                    // A misaligned access still spends one cycle in LS_ACC, with the memory
                    // port idle, so its error ack arrives with the same latency as a real access.
                    state_d      = LS_ACC;
                    last_grant_d = GRANT_LS;
                    lat_lane_d   = ls_addr[1:0];
                    lat_digit_d  = ls_digit;
                    lat_sign_d   = ls_sign;
                    lat_we_d     = ls_we;
                    lat_err_d    = ls_misaligned;
                    mem_req_d    = ~ls_misaligned;
                    mem_we_d     = ls_we & ~ls_misaligned;
                    mem_addr_d   = ls_misaligned ? 32'd0 : {ls_addr[31:2], 2'b00};
                    mem_be_d     = ls_misaligned ? 4'b0000 : ls_be_new;
                    mem_wdata_d  = ls_misaligned ? 32'd0 : ls_wdata_new;
`ifdef MEM_TIMEOUT_EN
                    tmo_d        = '0;
`endif
                end
            end
            IF_ACC, LS_ACC: begin
                if (lat_err_q) begin
                    finish     = 1'b1;
                    finish_err = 1'b1;
                end else if (mem_ready) begin
                    finish = 1'b1;
                    if (state_q == IF_ACC) begin
                        finish_data = mem_rdata;
                    end else if (!lat_we_q) begin
                        finish_data = extract_load(mem_rdata, lat_lane_q, lat_digit_q, lat_sign_q);
                    end
                end
`ifdef MEM_TIMEOUT_EN
                else begin
                    tmo_d = tmo_q + 8'd1;
                    if (tmo_q == 8'd254) begin
                        finish     = 1'b1;
                        finish_err = 1'b1;
                    end
                end
`endif
            end
            RESP: begin
                state_d    = IDLE;
                if_ack_d   = 1'b0;
                if_rdata_d = '0;
                if_err_d   = 1'b0;
                ls_ack_d   = 1'b0;
                ls_rdata_d = '0;
                ls_err_d   = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (finish) begin
            state_d     = RESP;
            mem_req_d   = 1'b0;
            mem_we_d    = 1'b0;
            mem_addr_d  = '0;
            mem_be_d    = '0;
            mem_wdata_d = '0;
            if (state_q == IF_ACC) begin
                if_ack_d   = 1'b1;
                if_err_d   = finish_err;
                if_rdata_d = finish_data;
            end else begin
                ls_ack_d   = 1'b1;
                ls_err_d   = finish_err;
                ls_rdata_d = finish_data;
            end
        end
    end

    // State and registered outputs; reset drops any transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= GRANT_LS;
            lat_lane_q   <= '0;
            lat_digit_q  <= '0;
            lat_sign_q   <= 1'b0;
            lat_we_q     <= 1'b0;
            lat_err_q    <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_be_q     <= '0;
            mem_wdata_q  <= '0;
            if_ack_q     <= 1'b0;
            if_rdata_q   <= '0;
            if_err_q     <= 1'b0;
            ls_ack_q     <= 1'b0;
            ls_rdata_q   <= '0;
            ls_err_q     <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            tmo_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            lat_lane_q   <= lat_lane_d;
            lat_digit_q  <= lat_digit_d;
            lat_sign_q   <= lat_sign_d;
            lat_we_q     <= lat_we_d;
            lat_err_q    <= lat_err_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_be_q     <= mem_be_d;
            mem_wdata_q  <= mem_wdata_d;
            if_ack_q     <= if_ack_d;
            if_rdata_q   <= if_rdata_d;
            if_err_q     <= if_err_d;
            ls_ack_q     <= ls_ack_d;
            ls_rdata_q   <= ls_rdata_d;
            ls_err_q     <= ls_err_d;
`ifdef MEM_TIMEOUT_EN
            tmo_q        <= tmo_d;
`endif
        end
    end

    assign if_ack    = if_ack_q;
    assign if_rdata  = if_rdata_q;
    assign if_err    = if_err_q;
    assign ls_ack    = ls_ack_q;
    assign ls_rdata  = ls_rdata_q;
    assign ls_err    = ls_err_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;
    assign stall     = (if_req & ~if_ack_q) | (ls_req & ~ls_ack_q);

endmodule
